// File: rtl/hist_pkg.sv
// Shared widths and FSM state type for the histogram memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hist_pkg;

  localparam int HIST_ADDR_W = 12;
  localparam int HIST_DATA_W = 16;
  localparam int FRAME_CNT_W = 8;

  // IDLE accepts words; RD/CMP form the peak-hold read-modify-write
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CMP  = 2'd2
  } state_t;

endpackage

// File: rtl/hist_mem_arbiter_if.sv
// Bundle of display, write-source, BRAM and frame-status signals of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: wr_valid/wr_ready handshake; the source holds the word until wr_ready.
interface hist_mem_arbiter_if;
  import hist_pkg::*;

  logic                   disp_req;
  logic [HIST_ADDR_W-1:0] disp_addr;
  logic [HIST_DATA_W-1:0] disp_data;

  logic                   wr_valid;
  logic                   wr_ready;
  logic [HIST_ADDR_W-1:0] wr_addr;
  logic [HIST_DATA_W-1:0] wr_data;
  logic                   wr_last;
  logic                   peak_clr;

  logic [HIST_ADDR_W-1:0] mem_addr;
  logic                   mem_we;
  logic [HIST_DATA_W-1:0] mem_wdata;
  logic [HIST_DATA_W-1:0] mem_rdata;

  logic                   frame_done;
  logic [FRAME_CNT_W-1:0] frame_count;

  // arbiter side: owns the BRAM port and the status outputs
  modport master (
    input  disp_req, disp_addr, wr_valid, wr_addr, wr_data, wr_last, peak_clr, mem_rdata,
    output disp_data, wr_ready, mem_addr, mem_we, mem_wdata, frame_done, frame_count
  );

  // environment side: display, FFT source and BRAM model
  modport slave (
    output disp_req, disp_addr, wr_valid, wr_addr, wr_data, wr_last, peak_clr, mem_rdata,
    input  disp_data, wr_ready, mem_addr, mem_we, mem_wdata, frame_done, frame_count
  );

endinterface

// File: rtl/hist_mem_arbiter.sv
// Shares one BRAM port between the display (absolute priority) and FFT bin writes; optional peak hold via HIST_PEAK_HOLD_EN.
// Latency: plain write commits in the accept cycle; peak-hold RMW takes 3 cycles (IDLE, RD, CMP); disp_data is 1 cycle after disp_addr.
// Backpressure: wr_ready is low whenever disp_req is high or an RMW is in flight; an aborted RMW is retried from IDLE.
module hist_mem_arbiter
  import hist_pkg::*;
(
  input logic              clk,
  input logic              rst,
  hist_mem_arbiter_if.master bus
);

  logic transfer;

  assign transfer      = bus.wr_valid & bus.wr_ready;
  assign bus.disp_data = bus.mem_rdata;

`ifdef HIST_PEAK_HOLD_EN
  state_t state, state_nxt;

  // state register; reset also abandons any RMW in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end
`endif

  // port steering, write strobe, handshake and next state
  always_comb begin
    bus.mem_addr  = bus.disp_req ? bus.disp_addr : bus.wr_addr;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = bus.wr_data;
    bus.wr_ready  = 1'b0;
`ifdef HIST_PEAK_HOLD_EN
    state_nxt = state;
    if (bus.disp_req) begin
      // display steals the port: any partial RMW is dropped and restarted later
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.wr_valid) begin
            if (bus.peak_clr) begin
              bus.mem_we   = 1'b1;
              bus.wr_ready = 1'b1;
            end else begin
              state_nxt = RD;
            end
          end
        end
        RD: begin
          state_nxt = CMP;
        end
        CMP: begin
          if (bus.mem_rdata > bus.wr_data) bus.mem_wdata = bus.mem_rdata;
          bus.mem_we   = 1'b1;
          bus.wr_ready = 1'b1;
          state_nxt    = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
`else
    if (!bus.disp_req && bus.wr_valid) begin
      bus.mem_we   = 1'b1;
      bus.wr_ready = 1'b1;
    end
`endif
    if (rst) begin
      bus.mem_we   = 1'b0;
      bus.wr_ready = 1'b0;
    end
  end

  // frame counter and one-cycle done pulse on the last bin of a frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.frame_count <= '0;
      bus.frame_done  <= 1'b0;
    end else begin
      bus.frame_done <= transfer & bus.wr_last;
      if (transfer && bus.wr_last) bus.frame_count <= bus.frame_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hist_mem_arbiter.sv
// Self-checking bench for hist_mem_arbiter: directed and random words against a reference model.
// Latency: checks sampled on the falling edge, inputs driven 1 ns after the rising edge.
// Backpressure: each word is held until the model predicts acceptance; bounded by a cycle budget.
module tb_hist_mem_arbiter;
  import hist_pkg::*;

`ifdef HIST_PEAK_HOLD_EN
  localparam bit PEAK = 1'b1;
`else
  localparam bit PEAK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hist_mem_arbiter_if bus();
  hist_mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  bit [15:0] bram    [0:4095];
  bit [15:0] ref_mem [0:4095];

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_cnt;
  bit         exp_done;
  int         done_seen;
  bit         wrap_seen;
  logic [7:0] prev_cnt;

  // BRAM model: synchronous write, 1-cycle registered read
  always @(posedge clk) begin
    if (bus.mem_we) bram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= bram[bus.mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // frame outputs reflect transfers of the previous cycle
  task automatic frame_step(input bit hs, input bit last);
    chk("frame_done", bus.frame_done, exp_done);
    chk("frame_count", bus.frame_count, exp_cnt);
    if (bus.frame_done === 1'b1) done_seen++;
    if (prev_cnt == 8'd255 && bus.frame_count == 8'd0) wrap_seen = 1'b1;
    prev_cnt = bus.frame_count;
    exp_done = hs && last;
    if (exp_done) exp_cnt = exp_cnt + 8'd1;
  endtask

  // offer one word; mask bit i forces disp_req in cycle i, rnd adds random display bursts
  task automatic offer(input logic [11:0] a, input logic [15:0] d, input bit last, input bit pc,
                       input logic [31:0] mask, input bit rnd, input logic [11:0] fixed_da, input bit use_fixed);
    int run = 0;
    int need;
    bit done = 1'b0;
    bit disp;
    bit exp_hs;
    logic [11:0] da;
    logic [15:0] expw;
    need = (PEAK && !pc) ? 3 : 1;
    expw = (PEAK && !pc && ref_mem[a] > d) ? ref_mem[a] : d;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    bus.wr_last  = last;
    bus.peak_clr = pc;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      disp = (cyc < 32) ? mask[cyc] : 1'b0;
      if (rnd && cyc < 20 && $urandom_range(0, 2) == 0) disp = 1'b1;
      da = use_fixed ? fixed_da : 12'($urandom_range(0, 4095));
      bus.disp_req  = disp;
      bus.disp_addr = da;
      run = disp ? 0 : run + 1;
      exp_hs = !disp && (run >= need);
      @(negedge clk);
      chk("mem_addr", bus.mem_addr, disp ? da : a);
      chk("wr_ready", bus.wr_ready, exp_hs);
      chk("mem_we", bus.mem_we, exp_hs);
      chk("disp_data", bus.disp_data, bus.mem_rdata);
      if (exp_hs) begin
        chk("mem_wdata", bus.mem_wdata, expw);
        done = 1'b1;
      end
      frame_step(exp_hs, last);
      @(posedge clk); #1;
    end
    chk("completed", done, 1);
    ref_mem[a] = expw;
    bus.wr_valid = 1'b0;
    bus.disp_req = 1'b0;
    bus.wr_last  = 1'b0;
    @(negedge clk);
    chk("idle_ready", bus.wr_ready, 0);
    chk("idle_we", bus.mem_we, 0);
    frame_step(1'b0, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] start_cnt;
    rst = 1'b1;
    bus.disp_req  = 1'b0;
    bus.disp_addr = '0;
    bus.wr_valid  = 1'b1;
    bus.wr_addr   = 12'h001;
    bus.wr_data   = 16'hBEEF;
    bus.wr_last   = 1'b1;
    bus.peak_clr  = 1'b1;
    exp_cnt   = '0;
    exp_done  = 1'b0;
    done_seen = 0;
    wrap_seen = 1'b0;
    prev_cnt  = '0;

    // reset state with a word on offer: nothing may be written or accepted
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", bus.mem_we, 0);
    chk("rst_ready", bus.wr_ready, 0);
    chk("rst_frame_count", bus.frame_count, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
    bus.peak_clr = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // plain write, then display priority for three cycles
    offer(12'h005, 16'h1234, 1'b0, 1'b0, 32'h0, 1'b0, 12'h000, 1'b0);
    offer(12'h006, 16'hABCD, 1'b0, 1'b0, 32'h7, 1'b0, 12'h3FF, 1'b1);

    // peak hold sequence at 0x010
    offer(12'h010, 16'h0800, 1'b0, 1'b1, 32'h0, 1'b0, 12'h000, 1'b0);
    offer(12'h010, 16'h0400, 1'b0, 1'b0, 32'h0, 1'b0, 12'h000, 1'b0);
    offer(12'h010, 16'h0900, 1'b0, 1'b0, 32'h0, 1'b0, 12'h000, 1'b0);
    offer(12'h010, 16'h0100, 1'b0, 1'b1, 32'h0, 1'b0, 12'h000, 1'b0);

    // display interrupting the third and the second cycle of a word
    offer(12'h011, 16'h0500, 1'b0, 1'b0, 32'h4, 1'b0, 12'h000, 1'b0);
    offer(12'h011, 16'h0300, 1'b0, 1'b0, 32'h2, 1'b0, 12'h000, 1'b0);

    // random words over a small address range so bins get revisited
    for (int i = 0; i < 200; i++) begin
      offer(12'($urandom_range(0, 31)), 16'($urandom), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), 32'h0, 1'b1, 12'h000, 1'b0);
    end

    // 256 frames: one pulse each and a full wrap of the counter
    start_cnt = exp_cnt;
    done_seen = 0;
    wrap_seen = 1'b0;
    for (int i = 0; i < 256; i++) begin
      offer(12'($urandom_range(0, 31)), 16'($urandom), 1'b1, ($urandom_range(0, 1) == 0),
            32'h0, 1'b0, 12'h000, 1'b0);
    end
    chk("frames_done", done_seen, 256);
    chk("frame_wrap_seen", wrap_seen, 1);
    chk("frame_count_cycle", bus.frame_count, start_cnt);

    // a frame so the counter is non-zero before reset
    offer(12'h003, 16'h0042, 1'b1, 1'b0, 32'h0, 1'b0, 12'h000, 1'b0);

    // reset in the middle of a word
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 12'h007;
    bus.wr_data  = 16'hFFFF;
    bus.wr_last  = 1'b1;
    bus.peak_clr = 1'b0;
    bus.disp_req = 1'b0;
`ifdef HIST_PEAK_HOLD_EN
    @(negedge clk);
    chk("rmw_first_we", bus.mem_we, 0);
    chk("rmw_first_ready", bus.wr_ready, 0);
    frame_step(1'b0, 1'b0);
    @(posedge clk); #1;
`endif
    rst = 1'b1;
    #1;
    chk("midrst_we", bus.mem_we, 0);
    chk("midrst_ready", bus.wr_ready, 0);
    @(negedge clk);
    chk("midrst_we_hold", bus.mem_we, 0);
    chk("midrst_ready_hold", bus.wr_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
    exp_cnt  = '0;
    exp_done = 1'b0;
    @(negedge clk);
    frame_step(1'b0, 1'b0);
    chk("bram_after_rst", bram[7], ref_mem[7]);
    @(posedge clk); #1;

    // the source re-offers the abandoned word
    offer(12'h007, 16'hFFFF, 1'b1, 1'b0, 32'h0, 1'b0, 12'h000, 1'b0);

    // memory contents must match the model exactly
    for (int a = 0; a < 32; a++) chk("bram_sweep", bram[a], ref_mem[a]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
